// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg
// Shared types for the counter monitor: event kind encoding, monitor FSM
// states and the event record stored in the event FIFO.
package count_monitor_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_WRAP_W = 8;

  // 0 is reserved: it only appears on the outputs while the FIFO is empty.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_WRAP = 2'd1,
    EV_HOLD = 2'd2,
    EV_JUMP = 2'd3
  } ev_kind_t;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Event record at the default widths; the top builds a width-matched
  // equivalent when WIDTH/WRAP_W are overridden.
  typedef struct packed {
    ev_kind_t                kind;
    logic [DEF_WIDTH-1:0]    value;
    logic [DEF_WRAP_W-1:0]   wraps;
  } event_t;

endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if
// Valid/ready event stream from the monitor to a logger or control stage.
//   ev_valid : head of the event FIFO holds an event
//   ev_ready : consumer accepts the head
//   ev_kind  : WRAP/HOLD/JUMP
//   ev_value : counter sample at the event
//   ev_wraps : wrap count after the event was applied
// master = monitor side, slave = consumer side.
interface count_monitor_if
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
) ();

  logic              ev_valid;
  logic              ev_ready;
  ev_kind_t          ev_kind;
  logic [WIDTH-1:0]  ev_value;
  logic [WRAP_W-1:0] ev_wraps;

  modport master (
    output ev_valid,
    output ev_kind,
    output ev_value,
    output ev_wraps,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_kind,
    input  ev_value,
    input  ev_wraps,
    output ev_ready
  );

endinterface

// File: rtl/count_monitor_event_fifo.sv
// count_monitor_event_fifo
// Synchronous FIFO for monitor events. A push into a full FIFO succeeds only
// when a pop happens in the same cycle; otherwise it is discarded.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data
//   i_pop      : consumer takes the head (ignored while empty)
//   o_data     : head entry, reads 0 while empty
//   o_valid    : FIFO not empty
//   o_full     : occupancy == DEPTH
//   o_level    : occupancy
module count_monitor_event_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;

  logic [PTR_W-1:0]  w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == PTR_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the head is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_level = w_level;

endmodule

// File: rtl/count_monitor.sv
// count_monitor
// Observes a free-running counter, classifies each sample transition as
// STEP/WRAP/HOLD/JUMP, counts wraps and queues non-step events for a consumer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_en        : monitoring enable; 0 freezes classification
//   i_q         : counter value under observation
//   ev_if       : event stream (master side)
//   o_wrap_cnt  : live wrap count
//   o_level     : event FIFO occupancy
//   o_drop_err  : sticky, an event was lost to a full FIFO
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic [WIDTH-1:0]        i_q,
  count_monitor_if.master         ev_if,
  output logic [WRAP_W-1:0]       o_wrap_cnt,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_drop_err
);

  typedef struct packed {
    ev_kind_t          kind;
    logic [WIDTH-1:0]  value;
    logic [WRAP_W-1:0] wraps;
  } ev_rec_t;

  localparam int unsigned      REC_W    = $bits(ev_rec_t);
  localparam logic [WIDTH-1:0] Q_MAX    = '1;
  localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  state_t            r_state,    w_state_nxt;
  logic [WIDTH-1:0]  r_prev_q,   w_prev_nxt;
  logic              r_hold,     w_hold_nxt;
  logic [WRAP_W-1:0] r_wrap_cnt, w_wrap_nxt;
  logic              r_drop_err, w_drop_nxt;

  logic              w_push;
  ev_kind_t          w_kind;
  logic [WIDTH-1:0]  w_prev_inc;
  ev_rec_t           w_rec;
  ev_rec_t           w_head_rec;
  logic [REC_W-1:0]  w_head;
  logic              w_fifo_valid;
  logic              w_full;
  logic              w_pop;

  assign w_prev_inc = r_prev_q + Q_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_PRIME;
      r_prev_q   <= '0;
      r_hold     <= 1'b0;
      r_wrap_cnt <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_q   <= w_prev_nxt;
      r_hold     <= w_hold_nxt;
      r_wrap_cnt <= w_wrap_nxt;
      r_drop_err <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev_q;
    w_hold_nxt  = r_hold;
    w_wrap_nxt  = r_wrap_cnt;
    w_push      = 1'b0;
    w_kind      = EV_NONE;
    unique case (r_state)
      ST_PRIME: begin
        if (i_en) begin
          w_prev_nxt  = i_q;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_en) begin
          w_prev_nxt = i_q;
          // Wrap is tested first so the step test never sees prev_q == max.
          if (r_prev_q == Q_MAX && i_q == '0) begin
            w_wrap_nxt = r_wrap_cnt + WRAP_ONE;
            w_kind     = EV_WRAP;
            w_push     = 1'b1;
            w_hold_nxt = 1'b0;
          end else if (i_q == w_prev_inc) begin
            w_hold_nxt = 1'b0;
          end else if (i_q == r_prev_q) begin
            // Only the first sample of a stall is reported.
            w_kind     = EV_HOLD;
            w_push     = !r_hold;
            w_hold_nxt = 1'b1;
          end else begin
            w_kind     = EV_JUMP;
            w_push     = 1'b1;
            w_hold_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_PRIME;
    endcase
  end

  // wraps field is the post-update count, which equals the current count for
  // every kind except WRAP.
  assign w_rec.kind  = w_kind;
  assign w_rec.value = i_q;
  assign w_rec.wraps = w_wrap_nxt;

  assign w_pop      = w_fifo_valid && ev_if.ev_ready;
  assign w_drop_nxt = r_drop_err | (w_push & w_full & ~w_pop);

  count_monitor_event_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (REC_W)
  ) u_event_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_full  (w_full),
    .o_level (o_level)
  );

  assign w_head_rec     = ev_rec_t'(w_head);
  assign ev_if.ev_valid = w_fifo_valid;
  assign ev_if.ev_kind  = w_head_rec.kind;
  assign ev_if.ev_value = w_head_rec.value;
  assign ev_if.ev_wraps = w_head_rec.wraps;

  assign o_wrap_cnt = r_wrap_cnt;
  assign o_drop_err = r_drop_err;

endmodule
